// File: rtl/fp_pkg.sv
// Shared binary32 helpers: FSM encodings, exponent limits, special constants
// and field extractors. Used by both the multiplier and the adder.
package fp_pkg;

  typedef enum logic [3:0] {
    GET_A   = 4'd0,
    GET_B   = 4'd1,
    UNPACK  = 4'd2,
    SPECIAL = 4'd3,
    NORM_A  = 4'd4,
    NORM_B  = 4'd5,
    MUL_0   = 4'd6,
    MUL_1   = 4'd7,
    NORM_1  = 4'd8,
    NORM_2  = 4'd9,
    ROUND   = 4'd10,
    PACK    = 4'd11,
    PUT_Z   = 4'd12
  } fp_state_e;

  // Exponents are carried unbiased as signed 10-bit values.
  localparam logic signed [9:0] BIAS = 10'sd127;
  localparam logic signed [9:0] EMIN = -10'sd126;

  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;

  function automatic logic f_sign(input logic [31:0] x);
    return x[31];
  endfunction

  function automatic logic [7:0] f_exp(input logic [31:0] x);
    return x[30:23];
  endfunction

  function automatic logic [22:0] f_frac(input logic [31:0] x);
    return x[22:0];
  endfunction

  function automatic logic is_nan(input logic [31:0] x);
    return (f_exp(x) == 8'hFF) && (f_frac(x) != 23'd0);
  endfunction

  function automatic logic is_inf(input logic [31:0] x);
    return (f_exp(x) == 8'hFF) && (f_frac(x) == 23'd0);
  endfunction

  function automatic logic is_zero(input logic [31:0] x);
    return (f_exp(x) == 8'h00) && (f_frac(x) == 23'd0);
  endfunction

endpackage

// File: rtl/multiplier.sv
// Multi-cycle binary32 multiplier, one operation in flight, stb/ack on every
// port. Subnormals are pre-normalised one bit per cycle; result is rounded
// to nearest, ties to even.
module multiplier
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  input  logic [31:0] input_b,
  input  logic        input_b_stb,
  output logic        input_b_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  fp_state_e          state, state_n;
  logic [31:0]        a, b, z, special_z;
  logic [23:0]        a_m, b_m, z_m;
  logic signed [9:0]  a_e, b_e, z_e;
  logic               z_s, guard, round_bit, sticky, special_hit;
  logic [47:0]        product;
  logic               sgn;

  assign sgn = f_sign(a) ^ f_sign(b);
  assign special_hit = is_nan(a) | is_nan(b) | is_inf(a) | is_inf(b) |
                       is_zero(a) | is_zero(b);

  // Special-case result, in priority order NaN / Inf*0, Inf, zero.
  always_comb begin
    special_z = {sgn, 31'd0};
    if (is_nan(a) || is_nan(b) || (is_inf(a) && is_zero(b)) ||
        (is_zero(a) && is_inf(b)))
      special_z = QNAN;
    else if (is_inf(a) || is_inf(b))
      special_z = {sgn, POS_INF[30:0]};
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= GET_A;
    else      state <= state_n;
  end

  // Next-state: loops in NORM_* hold until their normalise condition clears.
  always_comb begin
    state_n = state;
    case (state)
      GET_A:   if (input_a_ack && input_a_stb) state_n = GET_B;
      GET_B:   if (input_b_ack && input_b_stb) state_n = UNPACK;
      UNPACK:  state_n = SPECIAL;
      SPECIAL: state_n = special_hit ? PUT_Z : NORM_A;
      NORM_A:  if (a_m[23]) state_n = NORM_B;
      NORM_B:  if (b_m[23]) state_n = MUL_0;
      MUL_0:   state_n = MUL_1;
      MUL_1:   state_n = NORM_1;
      NORM_1:  if (z_m[23]) state_n = NORM_2;
      NORM_2:  if (z_e >= EMIN) state_n = ROUND;
      ROUND:   state_n = PACK;
      PACK:    state_n = PUT_Z;
      PUT_Z:   if (output_z_stb && output_z_ack) state_n = GET_A;
      default: state_n = GET_A;
    endcase
  end

  // Datapath and registered handshake outputs, updated per state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      input_a_ack  <= 1'b0;
      input_b_ack  <= 1'b0;
      output_z_stb <= 1'b0;
      output_z     <= '0;
      a <= '0; b <= '0; z <= '0;
      a_m <= '0; b_m <= '0; z_m <= '0;
      a_e <= '0; b_e <= '0; z_e <= '0;
      z_s <= 1'b0; guard <= 1'b0; round_bit <= 1'b0; sticky <= 1'b0;
      product <= '0;
    end else begin
      case (state)
        GET_A: begin
          input_a_ack <= 1'b1;
          if (input_a_ack && input_a_stb) begin
            a           <= input_a;
            input_a_ack <= 1'b0;
          end
        end
        GET_B: begin
          input_b_ack <= 1'b1;
          if (input_b_ack && input_b_stb) begin
            b           <= input_b;
            input_b_ack <= 1'b0;
          end
        end
        UNPACK: begin
          // Subnormals get no hidden bit and the minimum exponent.
          a_m <= {|f_exp(a), f_frac(a)};
          b_m <= {|f_exp(b), f_frac(b)};
          a_e <= (f_exp(a) == 8'd0) ? EMIN : $signed({2'b00, f_exp(a)}) - BIAS;
          b_e <= (f_exp(b) == 8'd0) ? EMIN : $signed({2'b00, f_exp(b)}) - BIAS;
        end
        SPECIAL: if (special_hit) z <= special_z;
        NORM_A: if (!a_m[23]) begin
          a_m <= a_m << 1;
          a_e <= a_e - 10'sd1;
        end
        NORM_B: if (!b_m[23]) begin
          b_m <= b_m << 1;
          b_e <= b_e - 10'sd1;
        end
        MUL_0: begin
          // +1 because product[47:24] puts the binary point after bit 47.
          z_s     <= sgn;
          z_e     <= a_e + b_e + 10'sd1;
          product <= 48'(a_m) * 48'(b_m);
        end
        MUL_1: begin
          z_m       <= product[47:24];
          guard     <= product[23];
          round_bit <= product[22];
          sticky    <= |product[21:0];
        end
        NORM_1: if (!z_m[23]) begin
          z_m       <= {z_m[22:0], guard};
          guard     <= round_bit;
          round_bit <= 1'b0;
          z_e       <= z_e - 10'sd1;
        end
        NORM_2: if (z_e < EMIN) begin
          // Denormalise: bits fall through guard/round into sticky.
          z_m       <= z_m >> 1;
          z_e       <= z_e + 10'sd1;
          guard     <= z_m[0];
          round_bit <= guard;
          sticky    <= sticky | round_bit;
        end
        ROUND: if (guard && (round_bit || sticky || z_m[0])) begin
          z_m <= z_m + 24'd1;
          if (z_m == 24'hFFFFFF) z_e <= z_e + 10'sd1;
        end
        PACK: begin
          if (z_e > BIAS)
            z <= {z_s, POS_INF[30:0]};
          else if (z_e == EMIN && !z_m[23])
            z <= {z_s, 8'h00, z_m[22:0]};
          else
            z <= {z_s, 8'(z_e + BIAS), z_m[22:0]};
        end
        PUT_Z: begin
          output_z_stb <= 1'b1;
          output_z     <= z;
          if (output_z_stb && output_z_ack) output_z_stb <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multiplier.sv
// Directed-vector bench for the binary32 multiplier plus handshake, reset
// and back-to-back random sequences.
module tb_multiplier;

  logic        clk, rst;
  logic [31:0] input_a, input_b, output_z;
  logic        input_a_stb, input_a_ack, input_b_stb, input_b_ack;
  logic        output_z_stb, output_z_ack;

  multiplier dut (
    .clk(clk), .rst(rst),
    .input_a(input_a), .input_a_stb(input_a_stb), .input_a_ack(input_a_ack),
    .input_b(input_b), .input_b_stb(input_b_stb), .input_b_ack(input_b_ack),
    .output_z(output_z), .output_z_stb(output_z_stb), .output_z_ack(output_z_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] z;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Present A then B; returns right after the B-handshake edge.
  task automatic send_ab(input logic [31:0] va, input logic [31:0] vb);
    int n;
    @(negedge clk);
    input_a = va; input_a_stb = 1'b1;
    n = 0;
    while (!input_a_ack && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("a_ack_timeout", 32'(input_a_ack), 32'd1);
    @(posedge clk); #1;
    input_a_stb = 1'b0;
    input_b = vb; input_b_stb = 1'b1;
    n = 0;
    while (!input_b_ack && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("b_ack_timeout", 32'(input_b_ack), 32'd1);
    @(posedge clk); #1;
    input_b_stb = 1'b0;
  endtask

  // Count edges until output_z_stb is seen high.
  task automatic wait_z(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!output_z_stb && lat < 400);
    if (!output_z_stb) chk("z_stb_timeout", 32'(output_z_stb), 32'd1);
  endtask

  task automatic consume();
    @(negedge clk);
    output_z_ack = 1'b1;
    @(posedge clk); #1;
    output_z_ack = 1'b0;
  endtask

  // Independent reference: exact product in double precision, then RNE to
  // single from the double's bit pattern. Valid for normal-range results.
  function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    logic [63:0] dx, dy, d;
    logic [10:0] ex, ey, e;
    logic [22:0] m;
    logic [28:0] rest;
    logic [7:0]  ef;
    ex = 11'(x[30:23]) + 11'd896;
    ey = 11'(y[30:23]) + 11'd896;
    dx = {x[31], ex, x[22:0], 29'd0};
    dy = {y[31], ey, y[22:0], 29'd0};
    d  = $realtobits($bitstoreal(dx) * $bitstoreal(dy));
    e    = d[62:52];
    m    = d[51:29];
    rest = d[28:0];
    ef   = 8'(e - 11'd896);
    if (rest > 29'h10000000 || (rest == 29'h10000000 && m[0])) begin
      if (m == 23'h7FFFFF) begin m = '0; ef = ef + 8'd1; end
      else m = m + 23'd1;
    end
    return {d[63], ef, m};
  endfunction

  initial begin
    int lat;
    logic [31:0] z0, ra, rb;
    logic held;

    // Latency: 11 base, +1 per NORM_A/B shift, NORM_1 shift and NORM_2 shift.
    vecs[0]  = '{32'h3FC00000, 32'hC0200000, 32'hC0700000, 12}; // mant product <2: one NORM_1 shift
    vecs[1]  = '{32'h3FC00000, 32'h3FC00000, 32'h40100000, 11}; // 2.25: no shift
    vecs[2]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 3};
    vecs[3]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 3};
    vecs[4]  = '{32'h00000001, 32'h4B000000, 32'h00800000, 35}; // 23 pre-norm + 1 NORM_1
    vecs[5]  = '{32'h00800000, 32'h3F000000, 32'h00400000, 13}; // 1 NORM_1 + 1 NORM_2
    vecs[6]  = '{32'h7F000000, 32'h7F000000, 32'h7F800000, 12};
    vecs[7]  = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 12};
    vecs[8]  = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 3};
    vecs[9]  = '{32'h00000000, 32'hC0A00000, 32'h80000000, 3};
    vecs[10] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 12};
    vecs[11] = '{32'h80000000, 32'h7F800000, 32'h7FC00000, 3};

    rst = 1'b0;
    input_a = '0; input_b = '0;
    input_a_stb = 1'b0; input_b_stb = 1'b0; output_z_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_a_ack", 32'(input_a_ack), 32'd0);
    chk("rst_b_ack", 32'(input_b_ack), 32'd0);
    chk("rst_z_stb", 32'(output_z_stb), 32'd0);
    chk("rst_z", output_z, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("first_a_ack", 32'(input_a_ack), 32'd1);

    for (int i = 0; i < 12; i++) begin
      send_ab(vecs[i].a, vecs[i].b);
      wait_z(lat);
      chk($sformatf("vec%0d_z", i), output_z, vecs[i].z);
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
      consume();
      chk($sformatf("vec%0d_stb_drop", i), 32'(output_z_stb), 32'd0);
    end

    // Back-pressure: result and stb held for 20 cycles without ack.
    send_ab(32'h3FC00000, 32'hC0200000);
    wait_z(lat);
    z0 = output_z;
    held = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (output_z !== z0 || output_z_stb !== 1'b1) held = 1'b0;
    end
    chk("hold_stable", 32'(held), 32'd1);
    chk("hold_z", output_z, 32'hC0700000);
    consume();
    chk("hold_stb_drop", 32'(output_z_stb), 32'd0);
    @(posedge clk); #1;
    chk("hold_a_ack_back", 32'(input_a_ack), 32'd1);

    // Reset in the middle of MUL: everything clears at once, no result.
    send_ab(32'h3FC00000, 32'h3FC00000);
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("midrst_outs", {29'd0, input_a_ack, input_b_ack, output_z_stb}, 32'd0);
    chk("midrst_z", output_z, 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_a_ack", 32'(input_a_ack), 32'd1);
    held = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (output_z_stb) held = 1'b1;
    end
    chk("midrst_no_out", 32'(held), 32'd0);

    // Back-to-back random normal operands against the real-arithmetic model.
    for (int i = 0; i < 16; i++) begin
      ra = {1'($urandom_range(1)), 8'($urandom_range(154, 100)), 23'($urandom)};
      rb = {1'($urandom_range(1)), 8'($urandom_range(154, 100)), 23'($urandom)};
      send_ab(ra, rb);
      wait_z(lat);
      chk($sformatf("rand%0d_%h_%h", i, ra, rb), output_z, ref_mul(ra, rb));
      consume();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
